// File: rtl/fifo_pkg.sv
// Shared defaults for the watermark FIFO: geometry, thresholds, occupancy type.
package fifo_pkg;

  localparam int unsigned DefDataWidth           = 8;
  localparam int unsigned DefIndexWidth          = 5;
  localparam int unsigned DefDepth               = 1 << DefIndexWidth;
  localparam int unsigned DefAlmostFullThreshold = 28;
  localparam int unsigned DefAlmostEmptyThreshold = 4;

  // Occupancy 0..depth needs one bit more than the storage index.
  typedef logic [DefIndexWidth:0] count_t;

  // Thresholds must be ordered and reachable for the flags to be meaningful.
  function automatic logic thresholds_ok(input int unsigned ae_thr,
                                         input int unsigned af_thr,
                                         input int unsigned depth);
    return (ae_thr < af_thr) && (af_thr <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one synchronous read port, no reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [1 << ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read port; returns the old word on a same-address write (read-before-write).
  always_ff @(posedge clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_watermark.sv
// Synchronous FIFO with registered occupancy, watermark flags and sticky error flags.
module fifo_watermark
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = DefDataWidth,
  parameter int unsigned INDEX_WIDTH            = DefIndexWidth,
  parameter int unsigned ALMOST_FULL_THRESHOLD  = DefAlmostFullThreshold,
  parameter int unsigned ALMOST_EMPTY_THRESHOLD = DefAlmostEmptyThreshold
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [INDEX_WIDTH:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;
  localparam int unsigned CW    = INDEX_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRESHOLD);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_THRESHOLD);

  if (!thresholds_ok(ALMOST_EMPTY_THRESHOLD, ALMOST_FULL_THRESHOLD, DEPTH)) begin : g_bad_thr
    $error("fifo_watermark: need ALMOST_EMPTY_THRESHOLD < ALMOST_FULL_THRESHOLD <= depth");
  end

  logic [CW-1:0]         r_wr_ptr, r_rd_ptr, r_count;
  logic                  r_overflow, r_underflow;
  logic                  r_rd_seen;
  logic                  w_full, w_empty;
  logic                  w_wr_acc, w_rd_acc;
  logic                  w_ovf_evt, w_udf_evt;
  logic [DATA_WIDTH-1:0] w_mem_rd_data;

  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  // A full FIFO still accepts a write when a read frees the oldest slot in the same cycle.
  assign w_wr_acc  = wr_en && (!w_full || rd_en);
  assign w_rd_acc  = rd_en && !w_empty;
  assign w_ovf_evt = wr_en && !rd_en && w_full;
  assign w_udf_evt = rd_en && w_empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (INDEX_WIDTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc && rst_n),
    .i_wr_addr (r_wr_ptr[INDEX_WIDTH-1:0]),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_acc && rst_n),
    .i_rd_addr (r_rd_ptr[INDEX_WIDTH-1:0]),
    .o_rd_data (w_mem_rd_data)
  );

  // Pointer and occupancy update; pointers wrap naturally modulo 2*depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + CW'(1);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CW'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - CW'(1);
    end
  end

  // Sticky error flags; a new event in the clear cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt)    r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_udf_evt)    r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

  // Storage has no reset, so the output reads as zero until the first accepted read.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_rd_seen <= 1'b0;
    else if (w_rd_acc) r_rd_seen <= 1'b1;
  end

  assign rd_data      = r_rd_seen ? w_mem_rd_data : '0;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_watermark.sv
// Directed table-driven bench for fifo_watermark with hand-written corner sequences.
module tb_fifo_watermark;

  localparam int DEPTH = 32;
  localparam int AF    = 28;
  localparam int AE    = 4;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, rd_en, err_clr;
  logic [7:0] wr_data, rd_data;
  logic [5:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int n_pass  = 0;
  int n_total = 0;
  int n_step  = 0;

  typedef struct {
    bit         rst_n;
    bit         wr_en;
    logic [7:0] wr_data;
    bit         rd_en;
    bit         err_clr;
    int         exp_count;
    bit         exp_ovf;
    bit         exp_udf;
    bit         chk_rd;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  fifo_watermark dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit rst, bit wr, logic [7:0] wd, bit rd, bit clr, int cnt,
                              bit ovf, bit udf, bit chk, logic [7:0] rdx);
    vec_t v;
    v.rst_n = rst; v.wr_en = wr; v.wr_data = wd; v.rd_en = rd; v.err_clr = clr;
    v.exp_count = cnt; v.exp_ovf = ovf; v.exp_udf = udf; v.chk_rd = chk; v.exp_rd = rdx;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, n_step, act, exp);
  endtask

  // Drive one cycle of inputs, let the edge pass, then sample the outputs.
  task automatic step(input vec_t v);
    rst_n   = v.rst_n;
    wr_en   = v.wr_en;
    wr_data = v.wr_data;
    rd_en   = v.rd_en;
    err_clr = v.err_clr;
    @(posedge clk);
    #1;
    n_step++;
    chk("count",        int'(count),        v.exp_count);
    chk("full",         int'(full),         int'(v.exp_count == DEPTH));
    chk("empty",        int'(empty),        int'(v.exp_count == 0));
    chk("almost_full",  int'(almost_full),  int'(v.exp_count >= AF));
    chk("almost_empty", int'(almost_empty), int'(v.exp_count <= AE));
    chk("overflow",     int'(overflow),     int'(v.exp_ovf));
    chk("underflow",    int'(underflow),    int'(v.exp_udf));
    if (v.chk_rd) chk("rd_data", int'(rd_data), int'(v.exp_rd));
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;

    // Reset, fill 0x01..0x20, drop 0xAA, drain in order, underflow, clear.
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h00));
    for (int i = 0; i < 32; i++) tbl.push_back(mk(1, 1, 8'(i + 1), 0, 0, i + 1, 0, 0, 1, 8'h00));
    tbl.push_back(mk(1, 1, 8'hAA, 0, 0, 32, 1, 0, 1, 8'h00));
    for (int i = 0; i < 32; i++) tbl.push_back(mk(1, 0, 8'h00, 1, 0, 31 - i, 1, 0, 1, 8'(i + 1)));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 1, 1, 1, 8'h20));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'h20));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h20));
    foreach (tbl[k]) step(tbl[k]);

    // Refill, then 40 simultaneous read/write cycles while full across pointer wrap.
    for (int i = 0; i < 32; i++) step(mk(1, 1, 8'(8'h40 + i), 0, 0, i + 1, 0, 0, 1, 8'h20));
    for (int i = 0; i < 40; i++)
      step(mk(1, 1, 8'(8'h60 + i), 1, 0, 32, 0, 0, 1,
              (i < 32) ? 8'(8'h40 + i) : 8'(8'h60 + i - 32)));
    for (int i = 0; i < 32; i++) step(mk(1, 0, 8'h00, 1, 0, 31 - i, 0, 0, 1, 8'(8'h68 + i)));

    // Empty with write+read: write lands, read refused, underflow set.
    step(mk(1, 1, 8'h5C, 1, 0, 1, 0, 1, 1, 8'h87));
    step(mk(1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h5C));
    // Clear coinciding with a fresh underflow: the event wins.
    step(mk(1, 0, 8'h00, 1, 1, 0, 0, 1, 1, 8'h5C));
    step(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'h5C));

    // Reset mid-operation with 10 entries; requests during reset are ignored.
    for (int i = 0; i < 10; i++) step(mk(1, 1, 8'(8'h10 + i), 0, 0, i + 1, 0, 0, 1, 8'h5C));
    step(mk(0, 1, 8'hEE, 1, 0, 0, 0, 0, 1, 8'h00));
    step(mk(1, 1, 8'h99, 0, 0, 1, 0, 0, 1, 8'h00));
    step(mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h99));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_watermark.md
FIFO_WATERMARK -- requirements
Module: fifo_watermark

Interface
REQ-001 The block SHALL expose these parameters, one per line:
- DATA_WIDTH, 8, bits per entry.
- INDEX_WIDTH, 5, pointer width; depth = 1<<INDEX_WIDTH (default 32).
- ALMOST_FULL_THRESHOLD, 28, occupancy at or above which almost_full asserts.
- ALMOST_EMPTY_THRESHOLD, 4, occupancy at or below which almost_empty asserts.
REQ-002 The block SHALL expose these ports, one per line:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  registered read data.
- count  out  INDEX_WIDTH+1  current occupancy, 0..depth.
- full  out  1  count == depth.
- empty  out  1  count == 0.
- almost_full  out  1  count >= ALMOST_FULL_THRESHOLD.
- almost_empty  out  1  count <= ALMOST_EMPTY_THRESHOLD.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was refused.
- err_clr  in  1  clears overflow and underflow.
REQ-003 The block SHALL use a single clock, clk, and a synchronous, active-low reset, rst_n.

Function
REQ-004 Accepted write: wr_en && (!full || rd_en); stores wr_data at the write pointer, then the write pointer increments.
REQ-005 Accepted read: rd_en && !empty; rd_data <= entry at the read pointer, then the read pointer increments; 1-cycle latency from rd_en to rd_data.
REQ-006 rd_data SHALL hold its last value in every cycle without an accepted read.
REQ-007 Pointers SHALL be INDEX_WIDTH+1 bits wide; only the low INDEX_WIDTH bits address storage, and both wrap modulo 2*depth with no special case.
REQ-008 count SHALL be a register: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds depth, never below 0.
REQ-009 full, empty, almost_full and almost_empty SHALL be combinational decodes of the count register, valid in the same cycle as count.
REQ-010 Full with wr_en && rd_en: both accepted; count stays at depth; the oldest entry is read and the new entry stored.
REQ-011 Full with wr_en && !rd_en: write dropped; storage, pointers and count unchanged; overflow <= 1.
REQ-012 Empty with rd_en: read refused; rd_data holds; underflow <= 1; a simultaneous wr_en is still accepted (count becomes 1).
REQ-013 overflow and underflow SHALL stay set until err_clr; on err_clr they clear next cycle unless a new error event occurs in the same cycle, in which case the event wins (flag stays 1).
REQ-014 FIFO order SHALL be strict: data is read in write order with no loss except dropped writes per REQ-011.
REQ-015 Elaboration SHALL fail unless 0 <= ALMOST_EMPTY_THRESHOLD < ALMOST_FULL_THRESHOLD <= depth.

Reset
REQ-016 When rst_n is low at a rising clk edge: pointers = 0, count = 0, rd_data = 0, overflow = 0, underflow = 0; empty = 1, almost_empty = 1, full = 0, almost_full = 0.
REQ-017 Storage contents SHALL NOT be reset; reset asserted mid-operation discards all entries, and requests in the reset cycle are ignored.

Structure
REQ-018 A shared package fifo_pkg SHALL hold the default depth and threshold constants and a typedef for the occupancy count, for reuse by the top-level wrapper.
REQ-019 Storage SHALL be a sub-module, fifo_mem: a simple dual-port array with one synchronous write port and one synchronous read port, no reset. Pointers, count, flags and error logic SHALL live in fifo_watermark.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then write 0x01..0x20 (32 writes) -> full=1 and count=32 after the 32nd; almost_full first asserts at count=28; overflow=0.
- 33rd write of 0xAA while full -> overflow=1; then 32 reads -> rd_data 0x01..0x20 in order, each one cycle after its rd_en; 0xAA never appears.
- Read while empty -> underflow=1 and rd_data holds 0x20; err_clr for one cycle -> both flags 0 next cycle.
- While full, wr_en=rd_en=1 for 40 cycles -> count stays 32 and the read sequence continues in write order across pointer wrap.
- Empty, wr_en=rd_en=1 with 0x5C -> count=1, underflow=1; next read returns 0x5C.
- Reset asserted with count=10 -> count=0, empty=1, rd_data=0 next cycle; a following write/read returns the new data.
